minmax_tracker: RTL and testbench

Sequential min/max finder for unsigned sample streams. Accepts one WIDTH-bit sample per handshake, grouped into frames delimited by `in_last`. At frame end it presents the frame's maximum, minimum, their indices and the sample count on a valid/ready result port. It is the streaming, multi-cycle counterpart of the combinational 2-input max selector and is used wherever a value sequence has to be reduced over time.

---
 rtl/minmax_pkg.sv | 11 +
 rtl/minmax_tracker_if.sv | 36 +++
 rtl/minmax_compare.sv | 18 +
 rtl/minmax_tracker.sv | 136 +++++++++++++
 tb/tb_minmax_tracker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/minmax_pkg.sv
// Shared types for the min/max tracker: the two-state frame FSM encoding.
package minmax_pkg;

    // COLLECT accepts samples of the current frame; RESULT holds the finished
    // frame's summary on the output port until the consumer takes it.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

endpackage : minmax_pkg

// File: rtl/minmax_tracker_if.sv
// Sample-in / result-out stream bundle of the min/max tracker.
// master = the side that produces samples and consumes results,
// slave  = the tracker itself.
interface minmax_tracker_if #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 4
);
    // Sample stream
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;

    // Result stream
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_max;
    logic [WIDTH-1:0]     out_min;
    logic [IDX_WIDTH-1:0] out_max_idx;
    logic [IDX_WIDTH-1:0] out_min_idx;
    logic [IDX_WIDTH:0]   out_count;
    logic                 out_overflow;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_count, out_overflow
    );

endinterface : minmax_tracker_if

// File: rtl/minmax_compare.sv
// Combinational extreme-update decision for one incoming sample.
// Strict comparisons make ties keep the earliest index; the first sample of a
// frame always loads both extremes.
module minmax_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic             first_i,
    output logic             take_max_o,
    output logic             take_min_o
);

    assign take_max_o = first_i || (sample_i > max_i);
    assign take_min_o = first_i || (sample_i < min_i);

endmodule : minmax_compare

// File: rtl/minmax_tracker.sv
// Streaming per-frame min/max finder: tracks max/min values, the index of their
// first occurrence and the saturating sample count, then presents the summary
// on a valid/ready result port for one frame at a time.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    minmax_tracker_if.slave   bus
);

    localparam int unsigned          FULL       = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH:0]   FULL_COUNT = FULL[IDX_WIDTH:0];
    localparam logic [IDX_WIDTH:0]   COUNT_ONE  = {{IDX_WIDTH{1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0] IDX_SAT    = '1;

    state_t               state_q;
    logic                 first_q;
    logic [WIDTH-1:0]     max_q,     max_d;
    logic [WIDTH-1:0]     min_q,     min_d;
    logic [IDX_WIDTH-1:0] max_idx_q, max_idx_d;
    logic [IDX_WIDTH-1:0] min_idx_q, min_idx_d;
    logic [IDX_WIDTH:0]   count_q,   count_d;
    logic                 ovf_q,     ovf_d;

    logic                 accept;
    logic                 saturated;
    logic [IDX_WIDTH-1:0] cur_idx;
    logic                 take_max;
    logic                 take_min;

    // Handshake flags are pure decodes of the state register.
    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == RESULT);
    assign accept        = bus.in_valid && (state_q == COLLECT);

    // Once count has reached 2**IDX_WIDTH, further samples share the last index.
    assign saturated = (count_q == FULL_COUNT);
    assign cur_idx   = first_q   ? '0
                     : saturated ? IDX_SAT
                     :             count_q[IDX_WIDTH-1:0];

    minmax_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .sample_i  (bus.in_data),
        .max_i     (max_q),
        .min_i     (min_q),
        .first_i   (first_q),
        .take_max_o(take_max),
        .take_min_o(take_min)
    );

    // Next value of the extreme/index/count registers for an accepted sample.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (accept) begin
            if (take_max) begin
                max_d     = bus.in_data;
                max_idx_d = cur_idx;
            end
            if (take_min) begin
                min_d     = bus.in_data;
                min_idx_d = cur_idx;
            end
            if (first_q) begin
                count_d = COUNT_ONE;
                ovf_d   = 1'b0;
            end else if (saturated) begin
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end
    end

    // Frame FSM plus the datapath registers that feed the result port directly.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: datapath registers are reset too because their reset values are visible on out_*.
            state_q   <= COLLECT;
            first_q   <= 1'b1;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        first_q <= 1'b0;
                        if (bus.in_last) begin
                            state_q <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        state_q <= COLLECT;
                        first_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    first_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_max      = max_q;
    assign bus.out_min      = min_q;
    assign bus.out_max_idx  = max_idx_q;
    assign bus.out_min_idx  = min_idx_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = ovf_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: the driver pushes the expected frame
// summary when a frame's last sample is accepted, the monitor compares it on
// every cycle the result is presented.
module tb_minmax_tracker;

    localparam int WIDTH     = 4;
    localparam int IDX_WIDTH = 4;
    localparam int FULL      = 2 ** IDX_WIDTH;
    localparam int BUDGET    = 300;

    typedef struct {
        int mx;
        int mn;
        int mx_idx;
        int mn_idx;
        int cnt;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    minmax_tracker_if #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

    minmax_tracker #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   low_run  = 0;
    int   last_low_run  = 0;
    int   last_xfer_cyc = 0;
    int   last_acc_cyc  = 0;
    bit   rand_ready    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: summary of a whole frame straight from the value list.
    function automatic exp_t model(input int vals[$]);
        exp_t r;
        int n = vals.size();
        r.mx = vals[0]; r.mn = vals[0]; r.mx_idx = 0; r.mn_idx = 0;
        for (int i = 1; i < n; i++) begin
            if (vals[i] > r.mx) begin r.mx = vals[i]; r.mx_idx = (i < FULL) ? i : FULL - 1; end
            if (vals[i] < r.mn) begin r.mn = vals[i]; r.mn_idx = (i < FULL) ? i : FULL - 1; end
        end
        r.cnt = (n > FULL) ? FULL : n;
        r.ovf = (n > FULL) ? 1 : 0;
        return r;
    endfunction

    // Monitor: compares the presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                check("in_ready_in_result", bus.in_ready, 0);
                check("results_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    check("out_max",      bus.out_max,      exp_q[0].mx);
                    check("out_min",      bus.out_min,      exp_q[0].mn);
                    check("out_max_idx",  bus.out_max_idx,  exp_q[0].mx_idx);
                    check("out_min_idx",  bus.out_min_idx,  exp_q[0].mn_idx);
                    check("out_count",    bus.out_count,    exp_q[0].cnt);
                    check("out_overflow", bus.out_overflow, exp_q[0].ovf);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        last_xfer_cyc = cyc + 1;
                    end
                end
            end
            if (!bus.in_ready) begin
                low_run++;
            end else begin
                if (low_run > 0) last_low_run = low_run;
                low_run = 0;
            end
        end
    end

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_sample(input int d, input bit last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'(d);
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > BUDGET) begin
                failures++;
                $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles", n);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
    endtask

    task automatic send_frame(input int vals[$], input bit gaps);
        for (int i = 0; i < vals.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = WIDTH'($urandom);
                bus.in_last  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            send_sample(vals[i], i == vals.size() - 1);
        end
        exp_q.push_back(model(vals));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int v[$];
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_max",   bus.out_max, 0);
        check("rst_out_count", bus.out_count, 0);
        @(posedge clk);
        #1;
        low_run = 0;

        // Frame 3,9,1,9,4: one-cycle latency, single dead input cycle.
        v = '{3, 9, 1, 9, 4};
        send_frame(v, 0);
        idle();
        @(negedge clk);
        check("latency_out_valid", bus.out_valid, 1);
        drain("drain_basic");
        check("dead_cycles", last_low_run, 1);

        // Single-sample frame.
        v = '{7};
        send_frame(v, 0);
        idle();
        drain("drain_single");

        // Result back-pressure with the next sample waiting.
        bus.out_ready = 1'b0;
        v = '{1, 2};
        send_frame(v, 0);
        fork
            begin
                v = '{5};
                send_frame(v, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle();
        check("accept_after_xfer", last_acc_cyc, last_xfer_cyc + 1);
        drain("drain_backpressure");

        // 18 descending, wrapping samples: saturation and overflow.
        v = {};
        for (int i = 0; i < 18; i++) v.push_back((15 - i) & 15);
        send_frame(v, 0);
        idle();
        drain("drain_overflow");

        // Reset in the middle of a frame discards it.
        send_sample(9, 0);
        send_sample(1, 0);
        send_sample(12, 0);
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid",   bus.out_valid, 0);
        check("mid_rst_in_ready",    bus.in_ready, 1);
        check("mid_rst_out_max",     bus.out_max, 0);
        check("mid_rst_out_min",     bus.out_min, 0);
        check("mid_rst_out_count",   bus.out_count, 0);
        check("mid_rst_out_max_idx", bus.out_max_idx, 0);
        check("mid_rst_out_overflow", bus.out_overflow, 0);
        @(posedge clk);
        #1;
        v = '{2, 6};
        send_frame(v, 0);
        idle();
        drain("drain_after_reset");

        // Back-to-back frames with in_valid held high.
        v = '{8, 8};
        send_frame(v, 0);
        v = '{0, 15};
        send_frame(v, 0);
        idle();
        drain("drain_back_to_back");

        // Randomized frames, gaps and consumer back-pressure.
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 20);
            v = {};
            for (int i = 0; i < len; i++) v.push_back($urandom_range(0, 15));
            send_frame(v, 1);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
        rand_ready = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_minmax_tracker
